// File: rtl/branch_resolver.sv
// branch_resolver: checks in-order IF predictions against EX outcomes, issuing redirect/flush and predictor updates
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_IF,
  input  logic             pred_taken_IF,
  input  logic [31:0]      pred_addr_IF,
  output logic             full,
  input  logic             ready_in,
  input  logic             res_valid_EX,
  input  logic             jump_alw_EX,
  input  logic             taken_EX,
  input  logic [31:0]      target_EX,
  input  logic [31:0]      PC_EX,
  output logic             redirect,
  output logic [31:0]      redirect_addr,
  output logic             flush,
  output logic             upd_ena_EX,
  output logic             upd_alw_EX,
  output logic             upd_taken_EX,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [1:0]       err
);
  localparam int AW = $clog2(DEPTH);
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_nx;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [32:0] mem [DEPTH];
  logic [FCW-1:0] fcnt;
  logic [32:0] head;
  logic [31:0] actual;
  logic empty, attempt, pop, push, mispred, kill, ovf, unf;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head = mem[rd_ptr[AW-1:0]];
  assign attempt = res_valid_EX && ready_in && state == IDLE;
  assign pop = attempt && !empty;
  assign push = push_IF && !flush && (!full || pop);
  assign actual = taken_EX ? target_EX : PC_EX + 32'd4;
  assign mispred = (head[32] != taken_EX) || (taken_EX && head[31:0] != target_EX);
  assign kill = pop && mispred;
  assign ovf = push_IF && !flush && full && !pop;
  assign unf = attempt && empty;
  always_comb begin
    flush = state == FLUSH;
    state_nx = kill ? FLUSH : (flush && fcnt == '0) ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {pred_taken_IF, pred_addr_IF};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fcnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      redirect <= 1'b0;
      redirect_addr <= '0;
      upd_ena_EX <= 1'b0;
      upd_alw_EX <= 1'b0;
      upd_taken_EX <= 1'b0;
      branch_cnt <= '0;
      mispred_cnt <= '0;
      err <= '0;
    end else begin
      state <= state_nx;
      fcnt <= kill ? FCW'(FLUSH_CYCLES - 1) : (flush && fcnt != '0) ? fcnt - FCW'(1) : fcnt;
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      wr_ptr <= kill ? rd_ptr + (AW+1)'(1) : wr_ptr + (AW+1)'(push);
      redirect <= kill;
      if (kill) redirect_addr <= actual;
      upd_ena_EX <= pop;
      upd_alw_EX <= pop && jump_alw_EX;
      upd_taken_EX <= pop && taken_EX;
      if (pop && !(&branch_cnt)) branch_cnt <= branch_cnt + CNT_W'(1);
      if (kill && !(&mispred_cnt)) mispred_cnt <= mispred_cnt + CNT_W'(1);
      err <= err | {ovf, unf};
    end
  end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed scenario tasks with hand-computed expectations for branch_resolver
module tb_branch_resolver;
  logic        clk = 1'b0;
  logic        reset, push_IF, pred_taken_IF, ready_in, res_valid_EX, jump_alw_EX, taken_EX;
  logic [31:0] pred_addr_IF, target_EX, PC_EX;
  logic        full, redirect, flush, upd_ena_EX, upd_alw_EX, upd_taken_EX;
  logic [31:0] redirect_addr, branch_cnt, mispred_cnt;
  logic [1:0]  err;
  int tests = 0;
  int fails = 0;

  branch_resolver dut (
    .clk(clk), .reset(reset), .push_IF(push_IF), .pred_taken_IF(pred_taken_IF),
    .pred_addr_IF(pred_addr_IF), .full(full), .ready_in(ready_in), .res_valid_EX(res_valid_EX),
    .jump_alw_EX(jump_alw_EX), .taken_EX(taken_EX), .target_EX(target_EX), .PC_EX(PC_EX),
    .redirect(redirect), .redirect_addr(redirect_addr), .flush(flush), .upd_ena_EX(upd_ena_EX),
    .upd_alw_EX(upd_alw_EX), .upd_taken_EX(upd_taken_EX), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic t, input logic [31:0] a);
    push_IF = 1'b1; pred_taken_IF = t; pred_addr_IF = a;
    step();
    push_IF = 1'b0;
  endtask

  task automatic resolve(input logic alw, input logic t, input logic [31:0] tgt, input logic [31:0] pc);
    res_valid_EX = 1'b1; jump_alw_EX = alw; taken_EX = t; target_EX = tgt; PC_EX = pc;
    step();
    res_valid_EX = 1'b0; jump_alw_EX = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    tests++; if ({redirect, flush, full, upd_ena_EX, upd_alw_EX, upd_taken_EX} !== 6'b0) begin fails++; $display("FAIL reset_flags got %b exp 000000", {redirect, flush, full, upd_ena_EX, upd_alw_EX, upd_taken_EX}); end
    tests++; if ({redirect_addr, branch_cnt, mispred_cnt} !== 96'b0 || err !== 2'b00) begin fails++; $display("FAIL reset_regs addr=%0h bc=%0d mc=%0d err=%b exp all 0", redirect_addr, branch_cnt, mispred_cnt, err); end
  endtask

  task automatic test_correct();
    push(1'b1, 32'h100);
    resolve(1'b0, 1'b1, 32'h100, 32'hF8);
    tests++; if (redirect !== 1'b0) begin fails++; $display("FAIL t1_redirect got %b exp 0", redirect); end
    tests++; if ({upd_ena_EX, upd_alw_EX, upd_taken_EX} !== 3'b101) begin fails++; $display("FAIL t1_upd got %b exp 101", {upd_ena_EX, upd_alw_EX, upd_taken_EX}); end
    tests++; if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd0) begin fails++; $display("FAIL t1_cnt got bc=%0d mc=%0d exp 1/0", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_mispredict_taken();
    push(1'b0, 32'h204);
    resolve(1'b0, 1'b1, 32'h300, 32'h200);
    tests++; if (redirect !== 1'b1 || redirect_addr !== 32'h300) begin fails++; $display("FAIL t2_redirect got %b/%0h exp 1/300", redirect, redirect_addr); end
    tests++; if (flush !== 1'b1 || mispred_cnt !== 32'd1 || branch_cnt !== 32'd2) begin fails++; $display("FAIL t2_state got fl=%b mc=%0d bc=%0d exp 1/1/2", flush, mispred_cnt, branch_cnt); end
    step();
    tests++; if (redirect !== 1'b0 || flush !== 1'b1) begin fails++; $display("FAIL t2_flush2 got rd=%b fl=%b exp 0/1", redirect, flush); end
    step();
    tests++; if (flush !== 1'b0 || full !== 1'b0 || redirect_addr !== 32'h300) begin fails++; $display("FAIL t2_end got fl=%b full=%b addr=%0h exp 0/0/300", flush, full, redirect_addr); end
  endtask

  task automatic test_mispredict_not_taken();
    push(1'b1, 32'h500);
    push_IF = 1'b1; pred_taken_IF = 1'b1; pred_addr_IF = 32'h600;
    resolve(1'b0, 1'b0, 32'h500, 32'h400);
    tests++; if (redirect !== 1'b1 || redirect_addr !== 32'h404 || flush !== 1'b1) begin fails++; $display("FAIL t3_redirect got %b/%0h fl=%b exp 1/404/1", redirect, redirect_addr, flush); end
    step();
    step();
    push_IF = 1'b0;
    tests++; if (flush !== 1'b0 || err !== 2'b00) begin fails++; $display("FAIL t3_flushdone got fl=%b err=%b exp 0/00", flush, err); end
    resolve(1'b0, 1'b1, 32'h600, 32'h5FC);
    tests++; if (err !== 2'b01 || full !== 1'b0 || redirect !== 1'b0 || upd_ena_EX !== 1'b0) begin fails++; $display("FAIL t3_underflow got err=%b full=%b rd=%b upd=%b exp 01/0/0/0", err, full, redirect, upd_ena_EX); end
    tests++; if (branch_cnt !== 32'd3 || mispred_cnt !== 32'd2) begin fails++; $display("FAIL t3_cnt got bc=%0d mc=%0d exp 3/2", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push(1'b1, 32'h1000 + 32'(i) * 4);
    tests++; if (full !== 1'b1 || err !== 2'b01) begin fails++; $display("FAIL t4_full got full=%b err=%b exp 1/01", full, err); end
    push(1'b1, 32'h1010);
    tests++; if (full !== 1'b1 || err !== 2'b11) begin fails++; $display("FAIL t4_overflow got full=%b err=%b exp 1/11", full, err); end
    push_IF = 1'b1; pred_taken_IF = 1'b1; pred_addr_IF = 32'h2000;
    resolve(1'b0, 1'b1, 32'h1000, 32'hFFC);
    push_IF = 1'b0;
    tests++; if (full !== 1'b1 || redirect !== 1'b0 || upd_ena_EX !== 1'b1) begin fails++; $display("FAIL t4_pushpop got full=%b rd=%b upd=%b exp 1/0/1", full, redirect, upd_ena_EX); end
    resolve(1'b0, 1'b1, 32'h1004, 32'h0);
    resolve(1'b0, 1'b1, 32'h1008, 32'h0);
    resolve(1'b0, 1'b1, 32'h100C, 32'h0);
    resolve(1'b0, 1'b1, 32'h2000, 32'h0);
    tests++; if (mispred_cnt !== 32'd2 || branch_cnt !== 32'd8 || full !== 1'b0 || redirect !== 1'b0) begin fails++; $display("FAIL t4_drain got mc=%0d bc=%0d full=%b rd=%b exp 2/8/0/0", mispred_cnt, branch_cnt, full, redirect); end
  endtask

  task automatic test_stall();
    push(1'b0, 32'h904);
    ready_in = 1'b0;
    resolve(1'b0, 1'b0, 32'h0, 32'h900);
    tests++; if (upd_ena_EX !== 1'b0 || branch_cnt !== 32'd8) begin fails++; $display("FAIL stall_nopop got upd=%b bc=%0d exp 0/8", upd_ena_EX, branch_cnt); end
    ready_in = 1'b1;
    resolve(1'b0, 1'b0, 32'h0, 32'h900);
    tests++; if (upd_ena_EX !== 1'b1 || upd_taken_EX !== 1'b0 || branch_cnt !== 32'd9 || redirect !== 1'b0) begin fails++; $display("FAIL stall_pop got upd=%b tk=%b bc=%0d rd=%b exp 1/0/9/0", upd_ena_EX, upd_taken_EX, branch_cnt, redirect); end
  endtask

  task automatic test_jalr();
    push(1'b0, 32'h3004);
    resolve(1'b1, 1'b1, 32'h8000, 32'h3000);
    tests++; if (redirect !== 1'b1 || redirect_addr !== 32'h8000) begin fails++; $display("FAIL jalr_redirect got %b/%0h exp 1/8000", redirect, redirect_addr); end
    tests++; if ({upd_ena_EX, upd_alw_EX, upd_taken_EX} !== 3'b111 || mispred_cnt !== 32'd3) begin fails++; $display("FAIL jalr_upd got %b mc=%0d exp 111/3", {upd_ena_EX, upd_alw_EX, upd_taken_EX}, mispred_cnt); end
    step();
    step();
  endtask

  task automatic test_reset_in_flush();
    push(1'b1, 32'h700);
    resolve(1'b0, 1'b0, 32'h700, 32'h600);
    tests++; if (flush !== 1'b1 || redirect_addr !== 32'h604) begin fails++; $display("FAIL rflush_pre got fl=%b addr=%0h exp 1/604", flush, redirect_addr); end
    push(1'b1, 32'h800);
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++; if (flush !== 1'b0 || redirect !== 1'b0 || full !== 1'b0 || err !== 2'b00) begin fails++; $display("FAIL rflush_flags got fl=%b rd=%b full=%b err=%b exp 0/0/0/00", flush, redirect, full, err); end
    tests++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0 || redirect_addr !== 32'd0) begin fails++; $display("FAIL rflush_regs got bc=%0d mc=%0d addr=%0h exp 0/0/0", branch_cnt, mispred_cnt, redirect_addr); end
    resolve(1'b0, 1'b1, 32'h800, 32'h0);
    tests++; if (err !== 2'b01 || upd_ena_EX !== 1'b0) begin fails++; $display("FAIL rflush_empty got err=%b upd=%b exp 01/0", err, upd_ena_EX); end
  endtask

  initial begin
    reset = 1'b1; push_IF = 1'b0; pred_taken_IF = 1'b0; pred_addr_IF = '0; ready_in = 1'b1;
    res_valid_EX = 1'b0; jump_alw_EX = 1'b0; taken_EX = 1'b0; target_EX = '0; PC_EX = '0;
    test_reset();
    test_correct();
    test_mispredict_taken();
    test_mispredict_not_taken();
    test_full();
    test_stall();
    test_jalr();
    test_reset_in_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
